// File: rtl/addsub15_pipe_stage.sv
// ---------------------------------------------------------------------------
// addsub15_pipe_stage
//
// Purpose:
//   Two-stage pipelined wrapper around a 15-bit carry-lookahead add/subtract
//   core. Stage 1 registers operands accepted on a valid/ready handshake and
//   feeds the combinational core. Stage 2 captures sum, carry out and signed
//   overflow into a result register that is offered on a valid/ready output
//   handshake. The block also keeps a sticky overflow flag and a count of
//   results accepted downstream.
//
// Optional feature (macro ADDSUB15_SAT_EN):
//   When defined, an overflowing result is replaced by the saturated value
//   15'h3FFF (A non-negative) or 15'h4000 (A negative) before the stage-2
//   register. out_ovf still reports the overflow. When undefined, out_s is
//   the wrapped core result and no saturation logic exists.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready combinational)
//   in_a, in_b            15-bit two's complement operands
//   in_mode               0 = A+B, 1 = A-B
//   in_tag                opaque tag returned with the result
//   out_valid / out_ready result beat handshake
//   out_s, out_cout       sum/difference and core carry out (NOT-borrow on sub)
//   out_ovf, out_tag      signed overflow and tag of the presented result
//   sticky_ovf            set when any overflowing result is accepted
//   clr_sticky            synchronous clear of sticky_ovf (a set wins)
//   op_count              results accepted downstream, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module addsub15_pipe_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_a,
  input  logic [14:0]      in_b,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  // Block carry-lookahead adder: three 5-bit groups. Group generate/propagate
  // terms feed a lookahead unit producing each group's carry-in, so the long
  // carry path crosses groups in one level instead of rippling 15 bits.
  // Returns {carry_out, sum[14:0]}.
  function automatic logic [15:0] cla15(input logic [14:0] a,
                                        input logic [14:0] b,
                                        input logic        cin);
    logic [14:0] g;
    logic [14:0] p;
    logic [14:0] s;
    logic [2:0]  gg;
    logic [2:0]  gp;
    logic [3:0]  gc;
    logic        c;
    int          idx;
    g = a & b;
    p = a ^ b;
    s = 15'h0000;
    for (int j = 0; j < 3; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        idx   = j * 5 + k;
        gg[j] = g[idx] | (p[idx] & gg[j]);
        gp[j] = gp[j] & p[idx];
      end
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & gc[0]);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & gc[0]);
    for (int j = 0; j < 3; j++) begin
      c = gc[j];
      for (int k = 0; k < 5; k++) begin
        idx    = j * 5 + k;
        s[idx] = p[idx] ^ c;
        c      = g[idx] | (p[idx] & c);
      end
    end
    return {gc[3], s};
  endfunction

  // Stage 1 (operand) registers
  logic             r_s1_valid;
  logic [14:0]      r_a;
  logic [14:0]      r_b;
  logic             r_mode;
  logic [TAG_W-1:0] r_tag;

  // Stage 2 (result) registers and status
  logic             r_out_valid;
  logic [14:0]      r_out_s;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_sticky;
  logic [CNT_W-1:0] r_op_count;

  // Combinational datapath / control
  logic        w_stall1;
  logic        w_stall2;
  logic        w_out_xfer;
  logic [14:0] w_b_eff;
  logic [15:0] w_sum;
  logic        w_ovf;
  logic [14:0] w_s_final;

  assign w_stall2   = r_out_valid & ~out_ready;
  assign w_stall1   = r_s1_valid & w_stall2;
  assign w_out_xfer = r_out_valid & out_ready;
  assign in_ready   = ~w_stall1;

  // Subtract is A + ~B + 1: invert B and inject mode as the carry in.
  assign w_b_eff = r_b ^ {15{r_mode}};
  assign w_sum   = cla15(r_a, w_b_eff, r_mode);
  // Overflow: effective operands agree in sign but the result does not.
  assign w_ovf   = (r_a[14] == w_b_eff[14]) & (w_sum[14] != r_a[14]);

`ifdef ADDSUB15_SAT_EN
  // Saturation mux ahead of the result register; direction follows A's sign.
  always_comb begin
    w_s_final = w_sum[14:0];
    if (w_ovf) begin
      if (r_a[14]) begin
        w_s_final = 15'h4000;
      end else begin
        w_s_final = 15'h3FFF;
      end
    end else begin
      w_s_final = w_sum[14:0];
    end
  end
`else
  assign w_s_final = w_sum[14:0];
`endif

  // Stage 1: capture the input beat whenever stage 1 is not held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= 15'h0000;
      r_b        <= 15'h0000;
      r_mode     <= 1'b0;
      r_tag      <= '0;
    end else if (!w_stall1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_mode <= in_mode;
        r_tag  <= in_tag;
      end
    end
  end

  // Stage 2: capture core results whenever the result register is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_s     <= 15'h0000;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_tag   <= '0;
    end else if (!w_stall2) begin
      r_out_valid <= r_s1_valid;
      r_out_s     <= w_s_final;
      r_out_cout  <= w_sum[15];
      r_out_ovf   <= w_ovf;
      r_out_tag   <= r_tag;
    end
  end

  // Sticky overflow: an accepted overflowing result takes priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_out_xfer && r_out_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_out_xfer) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_s      = r_out_s;
  assign out_cout   = r_out_cout;
  assign out_ovf    = r_out_ovf;
  assign out_tag    = r_out_tag;
  assign sticky_ovf = r_sticky;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_addsub15_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_addsub15_pipe_stage
//
// Self-checking bench for addsub15_pipe_stage. A reference model holds the
// in-flight operations in a queue; results are predicted with plain signed
// and unsigned integer arithmetic. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_addsub15_pipe_stage;

  typedef struct {
    logic [14:0] s;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
    int          acc_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_a;
  logic [14:0] in_b;
  logic        in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_s;
  logic        out_cout;
  logic        out_ovf;
  logic [3:0]  out_tag;
  logic        sticky_ovf;
  logic        clr_sticky;
  logic [15:0] op_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          n_recv   = 0;
  logic        exp_sticky = 1'b0;
  logic [15:0] exp_count  = 16'h0000;
  exp_t        q[$];

  always #5 clk = ~clk;

  addsub15_pipe_stage #(.TAG_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf),
    .out_tag    (out_tag),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: signed range test for overflow, unsigned compare for carry.
  function automatic exp_t predict(input logic [14:0] a, input logic [14:0] b,
                                   input logic m, input logic [3:0] tag);
    exp_t r;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   res;
    ua = int'(a);
    ub = int'(b);
    sa = a[14] ? ua - 32768 : ua;
    sb = b[14] ? ub - 32768 : ub;
    res = m ? (sa - sb) : (sa + sb);
    r.ovf  = (res > 16383) || (res < -16384);
    r.s    = 15'(res & 32767);
    r.cout = m ? (ua >= ub) : ((ua + ub) >= 32768);
`ifdef ADDSUB15_SAT_EN
    if (r.ovf) r.s = a[14] ? 15'h4000 : 15'h3FFF;
`endif
    r.tag = tag;
    r.acc_edge = 0;
    return r;
  endfunction

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic tick(output logic acc);
    logic exp_rdy;
    logic exp_v;
    logic in_x;
    logic out_x;
    exp_t e;
    #1;
    exp_rdy = !((q.size() == 2) && !out_ready);
    exp_v   = (q.size() > 0) && (cyc >= q[0].acc_edge + 1);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(exp_v));
    check_eq("op_count", 32'(op_count), 32'(exp_count));
    check_eq("sticky_ovf", 32'(sticky_ovf), 32'(exp_sticky));
    if (out_valid && q.size() > 0) begin
      check_eq("out_s", 32'(out_s), 32'(q[0].s));
      check_eq("out_cout", 32'(out_cout), 32'(q[0].cout));
      check_eq("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
      check_eq("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    in_x  = in_valid & exp_rdy;
    out_x = exp_v & out_ready;
    @(posedge clk);
    cyc++;
    if (out_x && q[0].ovf) exp_sticky = 1'b1;
    else if (clr_sticky) exp_sticky = 1'b0;
    if (out_x) begin
      void'(q.pop_front());
      exp_count = exp_count + 16'h0001;
      n_recv++;
    end
    if (in_x) begin
      e = predict(in_a, in_b, in_mode, in_tag);
      e.acc_edge = cyc;
      q.push_back(e);
    end
    acc = in_x;
    @(negedge clk);
  endtask

  // Directed op on an idle pipe: checks the result one edge after acceptance.
  task automatic directed(input logic [14:0] a, input logic [14:0] b, input logic m,
                          input logic [3:0] tag, input logic [14:0] es,
                          input logic ec, input logic eo);
    logic acc;
    int   n;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_tag = tag;
    out_ready = 1'b1; clr_sticky = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    check_eq("dir_accept", 32'(acc), 32'd1);
    tick(acc);
    #1;
    check_eq("dir_valid", 32'(out_valid), 32'd1);
    check_eq("dir_s", 32'(out_s), 32'(es));
    check_eq("dir_cout", 32'(out_cout), 32'(ec));
    check_eq("dir_ovf", 32'(out_ovf), 32'(eo));
    check_eq("dir_tag", 32'(out_tag), 32'(tag));
    tick(acc);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    q.delete();
    exp_count = 16'h0000;
    exp_sticky = 1'b0;
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int nops, input int max_cyc, input bit chk_drain);
    int   issued;
    int   cycles;
    logic acc;
    issued = 0; cycles = 0;
    while ((issued < nops || q.size() > 0 || in_valid) && cycles < max_cyc) begin
      if (!in_valid && issued < nops && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        case ($urandom_range(0, 3))
          0: in_a = 15'h3FF0 + 15'($urandom_range(0, 31));
          default: in_a = 15'($urandom);
        endcase
        in_b    = 15'($urandom);
        in_mode = 1'($urandom);
        in_tag  = 4'(issued);
        issued++;
      end
      out_ready  = 1'($urandom_range(0, 1));
      clr_sticky = ($urandom_range(0, 15) == 0);
      tick(acc);
      if (acc) in_valid = 1'b0;
      cycles++;
    end
    clr_sticky = 1'b0;
    if (chk_drain) check_eq("drain_done", 32'(q.size() == 0 && !in_valid), 32'd1);
  endtask

  initial begin
    logic acc;
    int   n;
    rst_n = 1'b0; in_valid = 1'b1; in_a = 15'd7; in_b = 15'd9; in_mode = 1'b0;
    in_tag = 4'd1; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_op_count", 32'(op_count), 32'd0);
    check_eq("reset_sticky", 32'(sticky_ovf), 32'd0);
    check_eq("reset_out_s", 32'(out_s), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick(acc);

    directed(15'd100, 15'd23, 1'b0, 4'd3, 15'd123, 1'b0, 1'b0);
    directed(15'd5, 15'd3, 1'b1, 4'd1, 15'd2, 1'b1, 1'b0);
    directed(15'd3, 15'd5, 1'b1, 4'd2, 15'h7FFE, 1'b0, 1'b0);
`ifdef ADDSUB15_SAT_EN
    directed(15'd16383, 15'd1, 1'b0, 4'd4, 15'h3FFF, 1'b0, 1'b1);
    directed(15'h4000, 15'd1, 1'b1, 4'd5, 15'h4000, 1'b1, 1'b1);
`else
    directed(15'd16383, 15'd1, 1'b0, 4'd4, 15'h4000, 1'b0, 1'b1);
    directed(15'h4000, 15'd1, 1'b1, 4'd5, 15'h3FFF, 1'b1, 1'b1);
`endif
    #1;
    check_eq("sticky_after_ovf", 32'(sticky_ovf), 32'd1);
    @(negedge clk);

    // Lone clear pulse
    clr_sticky = 1'b1; out_ready = 1'b1;
    tick(acc);
    clr_sticky = 1'b0;
    #1;
    check_eq("sticky_lone_clear", 32'(sticky_ovf), 32'd0);
    @(negedge clk);

    // Clear coinciding with an overflowing transfer: set wins
    in_valid = 1'b1; in_a = 15'd16383; in_b = 15'd1; in_mode = 1'b0; in_tag = 4'd9;
    out_ready = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    repeat (2) tick(acc);
    out_ready = 1'b1; clr_sticky = 1'b1;
    tick(acc);
    clr_sticky = 1'b0;
    #1;
    check_eq("sticky_set_wins", 32'(sticky_ovf), 32'd1);
    @(negedge clk);

    // Reset in the middle of a stream
    run_random(10, 6, 1'b0);
    mid_reset();
    repeat (2) tick(acc);

    // Eight tagged ops under random backpressure from a clean reset
    mid_reset();
    n_recv = 0;
    run_random(8, 500, 1'b1);
    check_eq("bp_op_count", 32'(op_count), 32'd8);
    check_eq("bp_recv", 32'(n_recv), 32'd8);

    // Longer randomized stream
    run_random(300, 4000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
